// File: rtl/rtttl_pkg.sv
// rtttl_pkg: shared definitions for the polyphonic RTTTL sequencer.
// Event word layout, note codes, duration codes and the voice FSM states.
package rtttl_pkg;

    localparam int EV_W       = 12;
    localparam int EV_NOTE_LSB = 0;
    localparam int EV_NOTE_W  = 4;
    localparam int EV_OCT_LSB = 4;
    localparam int EV_OCT_W   = 3;
    localparam int EV_DUR_LSB = 7;
    localparam int EV_DUR_W   = 3;
    localparam int EV_DOT_BIT = 10;

    localparam logic [3:0] NOTE_REST = 4'd0;
    localparam logic [3:0] NOTE_LAST = 4'd12;
    localparam logic [3:0] NOTE_END  = 4'd15;

    localparam logic [2:0] DUR_WHOLE   = 3'd0;
    localparam logic [2:0] DUR_HALF    = 3'd1;
    localparam logic [2:0] DUR_QUARTER = 3'd2;
    localparam logic [2:0] DUR_EIGHTH  = 3'd3;
    localparam logic [2:0] DUR_16TH    = 3'd4;
    localparam logic [2:0] DUR_32ND    = 3'd5;

    // Longest event is a dotted whole: 48 units.
    localparam int UNITS_W = 6;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        DECODE,
        PLAY,
        FIN
    } voice_state_t;

    function automatic logic [UNITS_W-1:0] ev_units(
        input logic [2:0] d,
        input logic       dot
    );
        logic [UNITS_W-1:0] u;
        if (d >= DUR_32ND)
            u = 6'd1;
        else
            u = 6'd32 >> d;
        if (dot)
            u = u + (u >> 1);
        return u;
    endfunction

endpackage

// File: rtl/rtttl_voice.sv
// rtttl_voice: one sequencer channel (fetch/decode/play FSM with duration counters).
// Ports: clk, rst, i_go/i_abort/i_restart/i_finish controls, i_tdiv, i_rom_data;
//        o_rom_addr, o_octave, o_note, o_gate, o_fin (in FIN or decoding END).
module rtttl_voice
    import rtttl_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int TICK_W = 20
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_go,
    input  logic              i_abort,
    input  logic              i_restart,
    input  logic              i_finish,
    input  logic [TICK_W-1:0] i_tdiv,
    input  logic [EV_W-1:0]   i_rom_data,
    output logic [ADDR_W-1:0] o_rom_addr,
    output logic [3:0]        o_octave,
    output logic [15:0]       o_note,
    output logic              o_gate,
    output logic              o_fin
);

    voice_state_t         r_state;
    logic [ADDR_W-1:0]    r_addr;
    logic [3:0]           r_oct;
    logic [15:0]          r_note;
    logic                 r_gate;
    logic [UNITS_W-1:0]   r_units;
    logic [TICK_W-1:0]    r_sub;

    logic [3:0]           w_ev_note;
    logic [2:0]           w_ev_oct;
    logic                 w_is_end;
    logic                 w_is_rest;
    logic [UNITS_W-1:0]   w_units;
    logic                 w_unused_rsvd;

    assign w_ev_note = i_rom_data[EV_NOTE_LSB +: EV_NOTE_W];
    assign w_ev_oct  = i_rom_data[EV_OCT_LSB +: EV_OCT_W];
    assign w_is_end  = (w_ev_note == NOTE_END);
    assign w_is_rest = (w_ev_note == NOTE_REST) || (w_ev_note > NOTE_LAST);
    assign w_units   = ev_units(i_rom_data[EV_DUR_LSB +: EV_DUR_W],
                                i_rom_data[EV_DOT_BIT]);
    assign w_unused_rsvd = i_rom_data[EV_W-1];

    // Reporting END during DECODE lets the controller act on the same edge,
    // so completion lands one cycle after the last END is decoded.
    assign o_fin = (r_state == FIN) || ((r_state == DECODE) && w_is_end);

    assign o_rom_addr = r_addr;
    assign o_octave   = r_oct;
    assign o_note     = r_note;
    assign o_gate     = r_gate;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_addr  <= '0;
            r_oct   <= '0;
            r_note  <= '0;
            r_gate  <= 1'b0;
            r_units <= '0;
            r_sub   <= '0;
        end else if (i_abort) begin
            r_state <= IDLE;
            r_addr  <= '0;
            r_gate  <= 1'b0;
        end else if (i_finish) begin
            r_state <= IDLE;
            r_gate  <= 1'b0;
        end else if (i_restart) begin
            r_state <= FETCH;
            r_addr  <= '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (i_go) begin
                        r_state <= FETCH;
                        r_addr  <= '0;
                    end
                end
                FETCH: r_state <= DECODE;
                DECODE: begin
                    if (w_is_end) begin
                        r_state <= FIN;
                    end else begin
                        r_state <= PLAY;
                        r_addr  <= r_addr + ADDR_W'(1);
                        r_units <= w_units - UNITS_W'(1);
                        r_sub   <= i_tdiv - TICK_W'(1);
                        if (w_is_rest) begin
                            r_oct  <= 4'd0;
                            r_note <= 16'h0001;
                            r_gate <= 1'b0;
                        end else begin
                            r_oct  <= {1'b0, w_ev_oct};
                            r_note <= 16'd1 << w_ev_note;
                            r_gate <= 1'b1;
                        end
                    end
                end
                PLAY: begin
                    if (r_sub == '0) begin
                        if (r_units == '0) begin
                            r_state <= FETCH;
                        end else begin
                            r_units <= r_units - UNITS_W'(1);
                            r_sub   <= i_tdiv - TICK_W'(1);
                        end
                    end else begin
                        r_sub <= r_sub - TICK_W'(1);
                    end
                end
                FIN: r_state <= FIN;
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/rtttl_poly_sequencer.sv
// rtttl_poly_sequencer: NUM_CH-voice RTTTL player with start/stop/loop control.
// Ports: clk, rst, start, stop, loop_en, tick_div, rom_data in;
//        rom_addr, octave, note, gate (per channel), busy, done out.
module rtttl_poly_sequencer
    import rtttl_pkg::*;
#(
    parameter int NUM_CH = 2,
    parameter int ADDR_W = 8,
    parameter int TICK_W = 20
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     stop,
    input  logic                     loop_en,
    input  logic [TICK_W-1:0]        tick_div,
    output logic [NUM_CH*ADDR_W-1:0] rom_addr,
    input  logic [NUM_CH*EV_W-1:0]   rom_data,
    output logic [NUM_CH*4-1:0]      octave,
    output logic [NUM_CH*16-1:0]     note,
    output logic [NUM_CH-1:0]        gate,
    output logic                     busy,
    output logic                     done
);

    logic              r_busy;
    logic              r_done;
    logic              r_loop;
    logic [TICK_W-1:0] r_tdiv;

    logic [NUM_CH-1:0] w_fin;
    logic              w_all_fin;
    logic              w_accept;
    logic              w_finish;
    logic              w_restart;

    assign w_all_fin = r_busy && (&w_fin);
    assign w_accept  = start && !r_busy && !stop;
    assign w_finish  = w_all_fin && !r_loop && !stop;
    assign w_restart = w_all_fin && r_loop && !stop;

    assign busy = r_busy;
    assign done = r_done;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy <= 1'b0;
            r_done <= 1'b0;
            r_loop <= 1'b0;
            r_tdiv <= TICK_W'(1);
        end else begin
            r_done <= 1'b0;
            if (stop) begin
                r_busy <= 1'b0;
            end else if (w_accept) begin
                r_busy <= 1'b1;
                r_loop <= loop_en;
                // A zero divider would never expire; run it as 1.
                r_tdiv <= (tick_div == '0) ? TICK_W'(1) : tick_div;
            end else if (w_finish) begin
                r_busy <= 1'b0;
                r_done <= 1'b1;
            end
        end
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        rtttl_voice #(
            .ADDR_W (ADDR_W),
            .TICK_W (TICK_W)
        ) u_voice (
            .clk        (clk),
            .rst        (rst),
            .i_go       (w_accept),
            .i_abort    (stop),
            .i_restart  (w_restart),
            .i_finish   (w_finish),
            .i_tdiv     (r_tdiv),
            .i_rom_data (rom_data[c*EV_W +: EV_W]),
            .o_rom_addr (rom_addr[c*ADDR_W +: ADDR_W]),
            .o_octave   (octave[c*4 +: 4]),
            .o_note     (note[c*16 +: 16]),
            .o_gate     (gate[c]),
            .o_fin      (w_fin[c])
        );
    end

endmodule

// File: tb/tb_rtttl_poly_sequencer.sv
// tb_rtttl_poly_sequencer: directed bench for the two-voice RTTTL sequencer.
// Song ROMs are modelled as registered reads; expected values are hand-derived.
module tb_rtttl_poly_sequencer;

    logic        clk;
    logic        rst;
    logic        start;
    logic        stop;
    logic        loop_en;
    logic [19:0] tick_div;
    logic [15:0] rom_addr;
    logic [23:0] rom_data;
    logic [7:0]  octave;
    logic [31:0] note;
    logic [1:0]  gate;
    logic        busy;
    logic        done;

    logic [11:0] mem0 [256];
    logic [11:0] mem1 [256];
    logic [11:0] rd0;
    logic [11:0] rd1;

    int checks;
    int failures;
    int gcnt;
    int dcnt;

    rtttl_poly_sequencer #(
        .NUM_CH (2),
        .ADDR_W (8),
        .TICK_W (20)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .stop     (stop),
        .loop_en  (loop_en),
        .tick_div (tick_div),
        .rom_addr (rom_addr),
        .rom_data (rom_data),
        .octave   (octave),
        .note     (note),
        .gate     (gate),
        .busy     (busy),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_ff @(posedge clk) begin
        rd0 <= mem0[rom_addr[7:0]];
        rd1 <= mem1[rom_addr[15:8]];
    end
    assign rom_data = {rd1, rd0};

    function automatic logic [11:0] ev(
        input logic [3:0] n,
        input logic [2:0] o,
        input logic [2:0] d,
        input logic       dot
    );
        return {1'b0, dot, d, o, n};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(
        input string       tag,
        input logic [31:0] obs,
        input logic [31:0] exp
    );
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Dotted quarter C5 (12 units) then D5 (1 unit) then END.
    task automatic run_dot(input logic [19:0] td, input string tag);
        mem0[0] = ev(4'd1, 3'd5, 3'd2, 1'b1);
        mem0[1] = ev(4'd3, 3'd5, 3'd5, 1'b0);
        mem0[2] = ev(4'd15, 3'd0, 3'd0, 1'b0);
        mem1[0] = ev(4'd15, 3'd0, 3'd0, 1'b0);
        tick_div = td;
        loop_en  = 1'b0;
        start    = 1'b1;
        for (int cyc = 1; cyc <= 22; cyc++) begin
            step();
            if (cyc == 1) start = 1'b0;
            if (cyc == 3) begin
                chk({tag, "_c_note"}, note[15:0], 32'h0002);
                chk({tag, "_c_oct"}, octave[3:0], 32'd5);
                chk({tag, "_c_gate"}, gate[0], 32'd1);
            end
            if (cyc == 16) chk({tag, "_c_last"}, note[15:0], 32'h0002);
            if (cyc == 17) chk({tag, "_d_note"}, note[15:0], 32'h0008);
            if (cyc == 19) begin
                chk({tag, "_done19"}, done, 32'd0);
                chk({tag, "_gate19"}, gate[0], 32'd1);
            end
            if (cyc == 20) begin
                chk({tag, "_done20"}, done, 32'd1);
                chk({tag, "_busy20"}, busy, 32'd0);
                chk({tag, "_gate20"}, gate[0], 32'd0);
            end
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        start    = 1'b1;
        stop     = 1'b0;
        loop_en  = 1'b0;
        tick_div = 20'd3;
        for (int i = 0; i < 256; i++) begin
            mem0[i] = ev(4'd15, 3'd0, 3'd0, 1'b0);
            mem1[i] = ev(4'd15, 3'd0, 3'd0, 1'b0);
        end

        // Reset held 3 cycles with start high
        step();
        step();
        step();
        rst   = 1'b0;
        start = 1'b0;
        chk("rst_addr", rom_addr, 32'd0);
        chk("rst_oct", octave, 32'd0);
        chk("rst_note", note, 32'd0);
        chk("rst_gate", gate, 32'd0);
        chk("rst_busy", busy, 32'd0);
        chk("rst_done", done, 32'd0);
        step();
        chk("rst_start_ign", busy, 32'd0);

        // C4 8 units, rest 4 units, END; tick_div 3.
        // start stays high while busy; tick_div/loop_en changes are ignored.
        mem0[0] = ev(4'd1, 3'd4, 3'd2, 1'b0);
        mem0[1] = ev(4'd0, 3'd0, 3'd3, 1'b0);
        mem0[2] = ev(4'd15, 3'd0, 3'd0, 1'b0);
        tick_div = 20'd3;
        start    = 1'b1;
        gcnt     = 0;
        dcnt     = 0;
        for (int cyc = 1; cyc <= 46; cyc++) begin
            step();
            if (cyc == 5) begin
                tick_div = 20'd7;
                loop_en  = 1'b1;
            end
            if (cyc == 10) start = 1'b0;
            if (gate[0]) gcnt++;
            if (done) dcnt++;
            if (cyc == 1) begin
                chk("s1_busy1", busy, 32'd1);
                chk("s1_addr1", rom_addr[7:0], 32'd0);
            end
            if (cyc == 2) chk("s1_gate2", gate[0], 32'd0);
            if (cyc == 3) begin
                chk("s1_note3", note[15:0], 32'h0002);
                chk("s1_oct3", octave[3:0], 32'd4);
                chk("s1_gate3", gate[0], 32'd1);
                chk("s1_addr3", rom_addr[7:0], 32'd1);
            end
            if (cyc == 28) begin
                chk("s1_note28", note[15:0], 32'h0002);
                chk("s1_gate28", gate[0], 32'd1);
            end
            if (cyc == 29) begin
                chk("s1_note29", note[15:0], 32'h0001);
                chk("s1_oct29", octave[3:0], 32'd0);
                chk("s1_gate29", gate[0], 32'd0);
            end
            if (cyc == 42) begin
                chk("s1_done42", done, 32'd0);
                chk("s1_busy42", busy, 32'd1);
            end
            if (cyc == 43) begin
                chk("s1_done43", done, 32'd1);
                chk("s1_busy43", busy, 32'd0);
                chk("s1_note43", note[15:0], 32'h0001);
            end
            if (cyc == 44) chk("s1_done44", done, 32'd0);
        end
        chk("s1_gate_cycles", gcnt, 32'd26);
        chk("s1_done_pulses", dcnt, 32'd1);
        chk("s1_idle_end", busy, 32'd0);

        // Dotted quarter, tick_div 1 then tick_div 0
        run_dot(20'd1, "dot_td1");
        run_dot(20'd0, "dot_td0");

        // Loop: ch0 E4 8 units, ch1 G4 16 units; stop mid-note later
        mem0[0] = ev(4'd5, 3'd4, 3'd2, 1'b0);
        mem0[1] = ev(4'd15, 3'd0, 3'd0, 1'b0);
        mem1[0] = ev(4'd8, 3'd4, 3'd1, 1'b0);
        mem1[1] = ev(4'd15, 3'd0, 3'd0, 1'b0);
        tick_div = 20'd1;
        loop_en  = 1'b1;
        start    = 1'b1;
        dcnt     = 0;
        for (int cyc = 1; cyc <= 50; cyc++) begin
            step();
            if (cyc == 1) start = 1'b0;
            if (cyc == 45) stop = 1'b0;
            if (done) dcnt++;
            if (cyc == 3) begin
                chk("lp_a0_3", rom_addr[7:0], 32'd1);
                chk("lp_a1_3", rom_addr[15:8], 32'd1);
                chk("lp_n0_3", note[15:0], 32'h0020);
                chk("lp_n1_3", note[31:16], 32'h0100);
            end
            if (cyc == 13) chk("lp_a0_13", rom_addr[7:0], 32'd1);
            if (cyc == 20) begin
                chk("lp_a0_20", rom_addr[7:0], 32'd1);
                chk("lp_a1_20", rom_addr[15:8], 32'd1);
            end
            if (cyc == 21) begin
                chk("lp_a0_21", rom_addr[7:0], 32'd0);
                chk("lp_a1_21", rom_addr[15:8], 32'd0);
                chk("lp_busy21", busy, 32'd1);
            end
            if (cyc == 23) begin
                chk("lp_a0_23", rom_addr[7:0], 32'd1);
                chk("lp_a1_23", rom_addr[15:8], 32'd1);
                chk("lp_n1_23", note[31:16], 32'h0100);
            end
            if (cyc == 41) begin
                chk("lp_a0_41", rom_addr[7:0], 32'd0);
                chk("lp_a1_41", rom_addr[15:8], 32'd0);
            end
            if (cyc == 44) stop = 1'b1;
            if (cyc == 45) begin
                chk("stp_gate", gate, 32'd0);
                chk("stp_busy", busy, 32'd0);
                chk("stp_done", done, 32'd0);
                chk("stp_addr", rom_addr, 32'd0);
                chk("stp_n1_hold", note[31:16], 32'h0100);
                chk("stp_o1_hold", octave[7:4], 32'd4);
            end
        end
        chk("lp_no_done", dcnt, 32'd0);

        // start and stop together from idle
        loop_en = 1'b0;
        start   = 1'b1;
        stop    = 1'b1;
        step();
        start = 1'b0;
        stop  = 1'b0;
        chk("ss_busy", busy, 32'd0);
        step();
        step();
        chk("ss_busy_later", busy, 32'd0);
        chk("ss_gate_later", gate, 32'd0);

        // Address wrap: 256 one-unit events, no END
        for (int i = 0; i < 256; i++) mem0[i] = ev(4'd1, 3'd3, 3'd5, 1'b0);
        mem0[0]   = ev(4'd10, 3'd3, 3'd5, 1'b0);
        mem0[254] = ev(4'd5, 3'd3, 3'd5, 1'b0);
        mem0[255] = ev(4'd6, 3'd3, 3'd5, 1'b0);
        mem1[0]   = ev(4'd15, 3'd0, 3'd0, 1'b0);
        tick_div  = 20'd1;
        start     = 1'b1;
        for (int cyc = 1; cyc <= 772; cyc++) begin
            step();
            if (cyc == 1) start = 1'b0;
            if (cyc == 765) chk("wr_n254", note[15:0], 32'h0020);
            if (cyc == 767) chk("wr_aFF", rom_addr[7:0], 32'hFF);
            if (cyc == 768) begin
                chk("wr_a00", rom_addr[7:0], 32'h00);
                chk("wr_n255", note[15:0], 32'h0040);
                chk("wr_busy", busy, 32'd1);
            end
            if (cyc == 771) chk("wr_n000", note[15:0], 32'h0400);
        end
        stop = 1'b1;
        step();
        stop = 1'b0;
        chk("wr_stop_busy", busy, 32'd0);
        chk("wr_stop_note", note[15:0], 32'h0400);

        // rst clears note/octave that stop left behind
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst2_note", note, 32'd0);
        chk("rst2_oct", octave, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rtttl_poly_sequencer.md
# rtttl_poly_sequencer

Multi-voice, parametrised successor to the single-voice RTTTL sequencer. Plays NUM_CH independent note streams from per-channel synchronous song memories. Each stream has a runtime-programmable tempo divider, dotted durations, a rest/end encoding, a loop mode and abort. It sits between the song ROMs and the per-voice tone generators, and drives octave/one-hot note/gate per channel.

## Interface
Parameters:
- NUM_CH, 2: number of voices.
- ADDR_W, 8: song memory address width per channel.
- TICK_W, 20: width of the tempo divider (clocks per 1/32-note unit).

Ports:
- clk  in  1  system clock; single clock domain.
- rst  in  1  synchronous, active-high reset.
- start  in  1  level sampled each cycle; starts playback when idle; ignored while busy.
- stop  in  1  synchronous abort; wins over start in the same cycle.
- loop_en  in  1  sampled with start; 1 = repeat song indefinitely.
- tick_div  in  TICK_W  clocks per unit, sampled with start; 0 is treated as 1.
- rom_addr  out  NUM_CH*ADDR_W  per-channel event address; channel c is at [c*ADDR_W +: ADDR_W].
- rom_data  in  NUM_CH*12  per-channel event word; valid the cycle after rom_addr.
- octave  out  NUM_CH*4  per-channel octave.
- note  out  NUM_CH*16  per-channel one-hot note: bit0 = rest, bits1..12 = C..B; bits13..15 are always 0.
- gate  out  NUM_CH  1 while a channel sounds a non-rest note.
- busy  out  1  playback in progress.
- done  out  1  one-cycle pulse at natural (non-loop) completion.

## Operation
- Event word fields:
  - [3:0] note: 0 = rest, 1..12 = C..B, 13..14 = rest, 15 = END.
  - [6:4] octave: zero-extended to 4 bits.
  - [9:7] duration code d: units = 32>>d; d≥5 gives 1 unit.
  - [10] dotted: units += units>>1.
  - [11] reserved, ignored.
- Per-channel FSM states and transitions:
  - IDLE → FETCH on accepted start.
  - FETCH: rom_addr presented → DECODE.
  - DECODE: rom_data registered. An END event → FIN. Any other event → PLAY; outputs are loaded and rom_addr increments.
  - PLAY: lasts exactly units*tick_div cycles, using a unit counter and a TICK_W sub-counter; then → FETCH.
  - FIN: waits for the controller.
- Controller:
  - When every channel is in FIN and loop_en is 0: done pulses, busy drops, and all channels go to IDLE. Outputs hold their last values, except that gate is cleared.
  - When every channel is in FIN and loop_en is 1: all channels reset rom_addr to 0 and enter FETCH in the same cycle. Channels therefore resynchronise every pass, and done never pulses.
- Rest events: note = 16'h0001, octave = 0, gate = 0.
- rom_addr wraps from 2^ADDR_W−1 to 0 with no special handling.
- Between events (FETCH and DECODE), octave, note and gate hold the previous event's values.
- stop or rst: on the next cycle every channel is IDLE; gate = 0, busy = 0, done = 0, rom_addr = 0.
  - rst additionally clears octave and note.
  - stop leaves octave and note holding their last values.
- start while busy is ignored. loop_en and tick_div are latched only when start is accepted.

## Timing
- Reset values of all outputs: rom_addr 0, octave 0, note 0, gate 0, busy 0, done 0.
- If start is accepted in cycle 0:
  - Cycle 1: busy = 1 and FETCH with rom_addr = 0.
  - Cycle 2: DECODE.
  - Cycle 3: outputs for event 0 are valid.
- Event period is units*tick_div + 2 cycles.
- The END event is decoded in cycle k. done and busy = 0 take effect in cycle k+1, counted from the last channel to decode END.
- Channels run their FSMs fully in parallel. There is no arbitration, because each channel has its own memory port.

## Structure
- Shared package rtttl_pkg contains:
  - event field offsets and widths;
  - NOTE_REST = 0 and NOTE_END = 15;
  - duration-code constants;
  - the voice state enum (IDLE, FETCH, DECODE, PLAY, FIN).
- Sub-module rtttl_voice implements one channel FSM and its counters; it is instantiated NUM_CH times by generate.
- The top level holds the start/stop/loop controller, the tick_div and loop_en latches, and the busy/done logic.

## Test plan
- Reset: hold rst for 3 cycles → all outputs are 0; start asserted during rst is ignored.
- NUM_CH=1, song [C4 d=2 (8 units), rest d=3 (4 units), END], tick_div=3, start in cycle 0:
  - busy = 1 in cycle 1.
  - note = 0x0002, octave = 4, gate = 1 in cycles 3–28.
  - note = 0x0001, gate = 0 from cycle 29; the rest plays for 12 cycles.
  - done pulses in cycle 43 and busy = 0 from cycle 43.
- Dotted quarter (d=2, bit10 = 1) with tick_div=1 → gate is high for exactly 12 cycles.
- NUM_CH=2, loop_en=1, channel 0 totals 8 units and channel 1 totals 16 units:
  - both rom_addr return to 0 in the same cycle after channel 1 finishes;
  - done never pulses;
  - the pattern repeats identically.
- stop in mid-note → next cycle gate = 0 and busy = 0 with no done. start asserted while busy has no effect. stop and start in the same cycle → the block stays idle.
- tick_div = 0 gives the same timing as tick_div = 1. A song placed at 0xFE (ADDR_W = 8) with no END before the wrap fetches from 0x00 after 0xFF.
